// File: rtl/counter_mod_updown.sv
// Up/down modulo counter with prescaler, synchronous clear/load, wrap or saturate
// at the bounds, a one-cycle terminal-count pulse and a sticky overflow flag.
module counter_mod_updown #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter int     SATURATE = 0,
    parameter int     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ena,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] result,
    output logic             tc,
    output logic             ovf
);

    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [PS_W-1:0]  presc;
    logic [WIDTH-1:0] step_next;
    logic             at_bound;
    logic             step_now;

    // Comparing against MAX_VAL keeps the test in WIDTH bits even when MODULUS = 2**WIDTH.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                    input logic dir);
        logic [WIDTH-1:0] nxt;
        if (dir) begin
            if (cur == MAX_VAL)
                nxt = (SATURATE != 0) ? cur : '0;
            else
                nxt = cur + WIDTH'(1);
        end else begin
            if (cur == '0)
                nxt = (SATURATE != 0) ? cur : MAX_VAL;
            else
                nxt = cur - WIDTH'(1);
        end
        return nxt;
    endfunction

    always_comb begin
        step_next = step_value(result, up_dn);
        at_bound  = up_dn ? (result == MAX_VAL) : (result == '0);
        step_now  = ena && (presc == PS_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
            presc  <= '0;
            tc     <= 1'b0;
            ovf    <= 1'b0;
        end else if (clr) begin
            result <= '0;
            presc  <= '0;
            tc     <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            result <= clamp_load(load_val);
            presc  <= '0;
            tc     <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (step_now) begin
                presc  <= '0;
                result <= step_next;
                if (at_bound) begin
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                end
            end else if (ena) begin
                presc <= presc + PS_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Directed bench for counter_mod_updown: five parameter variants share one stimulus
// bus; each phase checks the instance it targets against hand-computed values.
module tb_counter_mod_updown;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ena, up_dn, clr, load;
    logic [7:0] load_val;
    logic [7:0] res  [5];
    logic       tcv  [5];
    logic       ovfv [5];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // 0: defaults, 1: mod 10 wrap, 2: mod 10 saturate, 3: prescale 4, 4: mod 100 wrap
    counter_mod_updown #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .PRESCALE(1)) d0 (
        .clk(clk), .reset_n(reset_n), .ena(ena), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .result(res[0]), .tc(tcv[0]), .ovf(ovfv[0]));
    counter_mod_updown #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) d1 (
        .clk(clk), .reset_n(reset_n), .ena(ena), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .result(res[1]), .tc(tcv[1]), .ovf(ovfv[1]));
    counter_mod_updown #(.WIDTH(8), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) d2 (
        .clk(clk), .reset_n(reset_n), .ena(ena), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .result(res[2]), .tc(tcv[2]), .ovf(ovfv[2]));
    counter_mod_updown #(.WIDTH(8), .MODULUS(256), .SATURATE(0), .PRESCALE(4)) d3 (
        .clk(clk), .reset_n(reset_n), .ena(ena), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .result(res[3]), .tc(tcv[3]), .ovf(ovfv[3]));
    counter_mod_updown #(.WIDTH(8), .MODULUS(100), .SATURATE(0), .PRESCALE(1)) d4 (
        .clk(clk), .reset_n(reset_n), .ena(ena), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .result(res[4]), .tc(tcv[4]), .ovf(ovfv[4]));

    typedef struct {
        logic       ena;
        logic       up_dn;
        logic       clr;
        logic       load;
        logic [7:0] load_val;
        int         sel;
        logic [7:0] exp_res;
        logic       exp_tc;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input logic e, input logic u, input logic c, input logic l,
                         input logic [7:0] lv);
        ena = e; up_dn = u; clr = c; load = l; load_val = lv;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sel, input logic [7:0] er, input logic et, input logic eo,
                       input string name);
        n_vec++;
        if (res[sel] !== er || tcv[sel] !== et || ovfv[sel] !== eo) begin
            n_bad++;
            $display("FAIL %s dut%0d: got result=%0d tc=%b ovf=%b, expected result=%0d tc=%b ovf=%b",
                     name, sel, res[sel], tcv[sel], ovfv[sel], er, et, eo);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        // ena up_dn clr load load_val sel exp_res exp_tc exp_ovf
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   2, 8'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'd8,   2, 8'd8,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   2, 8'd9,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   2, 8'd9,  1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   2, 8'd9,  1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2, 8'd8,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2, 8'd7,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   2, 8'd7,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd200, 2, 8'd9,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'd3,   2, 8'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2, 8'd0,  1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   2, 8'd0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1, 8'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'd9,   1, 8'd9,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1, 8'd0,  1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1, 8'd1,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   4, 8'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'd5,   4, 8'd5,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'd77,  4, 8'd0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'd200, 4, 8'd99, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4, 8'd0,  1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'd42,  4, 8'd42, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   4, 8'd43, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   4, 8'd42, 1'b0, 1'b1});

        // Reset held for two edges, all instances idle at zero
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) chk(i, 8'd0, 1'b0, 1'b0, "reset");
        reset_n = 1'b1;

        // Default config counts up through a full wrap
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 260; k++) begin
            cycle();
            chk(0, 8'(k % 256), (k == 256), (k >= 256), "up_wrap256");
        end

        // Modulo-10 down count wrapping 0 -> 9
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        cycle();
        chk(1, 8'd0, 1'b0, 1'b0, "clr_mod10");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            chk(1, 8'((10 - (k % 10)) % 10), (k % 10 == 1), 1'b1, "down_wrap10");
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ena, tbl[i].up_dn, tbl[i].clr, tbl[i].load, tbl[i].load_val);
            cycle();
            chk(tbl[i].sel, tbl[i].exp_res, tbl[i].exp_tc, tbl[i].exp_ovf,
                $sformatf("table[%0d]", i));
        end

        // Prescale 4: five enabled cycles, three-cycle gap, seven more
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        cycle();
        chk(3, 8'd0, 1'b0, 1'b0, "clr_presc");
        e = 0;
        for (int i = 0; i < 15; i++) begin
            drive((i < 5 || i >= 8), 1'b1, 1'b0, 1'b0, 8'd0);
            if (ena) e++;
            cycle();
            chk(3, 8'(e / 4), 1'b0, 1'b0, "prescale4");
        end

        // Async reset mid-period with result=7, ovf=1
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'd9);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd7);
        cycle();
        chk(1, 8'd7, 1'b0, 1'b1, "pre_async_reset");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk(1, 8'd0, 1'b0, 1'b0, "async_reset");
        chk(3, 8'd0, 1'b0, 1'b0, "async_reset_presc");
        cycle();
        reset_n = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            cycle();
            chk(1, 8'(j), 1'b0, 1'b0, "resume_mod10");
            chk(3, 8'(j / 4), 1'b0, 1'b0, "resume_presc");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
- Parametrised successor to the team's 8-bit enable counter.
- Up/down modulo counter with enable, prescaler, synchronous clear, parallel load, wrap or saturate mode, terminal-count pulse and sticky overflow flag.
- Used as a general event/tick counter in datapath and timing blocks.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MODULUS, 256, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at bounds; 1 = hold at bounds.
- PRESCALE, 1, number of enabled cycles per count step (1..256); 1 = step on every enabled cycle.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low; assertion is immediate, release is synchronous to clk.
- ena  input  1  count enable; feeds the prescaler.
- up_dn  input  1  1 = count up, 0 = count down; sampled on the step cycle.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- result  output  WIDTH  current count, registered.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky flag; set on any wrap or saturate hit; cleared by clr or reset.

Behaviour:
- Reset (reset_n=0, asynchronous): result=0, tc=0, ovf=0, prescaler=0.
- Priority each clock edge: clr > load > step.
- clr: result=0, prescaler=0, ovf=0, tc=0.
- load:
  - result = load_val, clamped to MODULUS-1 if load_val >= MODULUS.
  - prescaler=0; tc=0; ovf unchanged.
- Prescaler:
  - When ena=1 and no clr/load: if prescaler==PRESCALE-1, prescaler goes to 0 and a step occurs; otherwise prescaler increments.
  - ena=0 holds the prescaler and result.
- Step, up (up_dn=1):
  - result<MODULUS-1: result+1.
  - result==MODULUS-1: wrap to 0 (SATURATE=0) or hold (SATURATE=1).
- Step, down (up_dn=0):
  - result>0: result-1.
  - result==0: wrap to MODULUS-1 (SATURATE=0) or hold (SATURATE=1).
- Bound event: a step taken at a bound, in either mode.
  - Sets tc=1 for exactly the next cycle only.
  - Sets ovf=1, which stays set until clr or reset.
- tc is 0 on every cycle without a bound event; a non-stepping ena cycle never raises tc.
- Latency: result updates on the clock edge where the step/load/clr is sampled, visible the following cycle.
- Arithmetic stays in WIDTH bits; result never leaves 0..MODULUS-1, including when MODULUS=2**WIDTH.
- Reset mid-count: outputs and prescaler go to 0 immediately; the first step after release requires PRESCALE enabled cycles.
- load and ena in the same cycle: load wins; the prescaler restarts from 0.
- up_dn may change on any cycle; only its value on the step cycle matters.

Test Plan:
- Defaults; reset_n=0 for 2 cycles, release, ena=1 up for 260 cycles -> result 0..255, wraps to 0 at cycle 256; tc=1 for one cycle; ovf=1 and stays 1.
- MODULUS=10, SATURATE=0, up_dn=0 from 0, ena=1 -> 9,8,...,0,9; tc pulses on each 0->9 wrap.
- MODULUS=10, SATURATE=1; load_val=8, then up 3 steps -> 9,9,9; ovf=1; tc pulses on each held step; then down 2 -> 8,7.
- PRESCALE=4, ena high for 12 cycles with a 3-cycle ena=0 gap after cycle 5 -> result=3; the prescaler holds during the gap.
- Priority: clr=1, load=1, ena=1 with result=5 -> result=0, ovf=0. Next, load=1, load_val=200 with MODULUS=100 -> result=99. Next, load with ena -> no step that cycle.
- Assert reset_n mid-clock-period while result=7 and ovf=1 -> result=0, ovf=0, tc=0 immediately, with no clk edge needed; after release, counting resumes from 0.
